instr_fetch_responder: RTL and testbench

Instruction-memory responder for the pipeline's fetch port. The PC/IF side issues word fetches with a request/ready handshake. This block returns the 32-bit big-endian instruction after a fixed, parameterised latency and flags misaligned or out-of-range addresses. A byte-wide load port preloads the program image before and between fetches. The block sits between the PC register and the IF stage register, and replaces the ideal zero-latency ROM.

---
 rtl/instr_fetch_responder.sv | 118 +++++++++++
 tb/tb_instr_fetch_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_fetch_responder
// Brief    : Byte-loadable instruction memory returning big-endian words after
//            a fixed latency, with misalignment / range error flagging.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module instr_fetch_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic              addr_err,
  output logic              busy
);

  localparam int          c_DEPTH    = 1 << ADDR_W;
  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_WAIT     = 2'd1;
  localparam logic [1:0]  c_RESP     = 2'd2;
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

  logic [7:0]        r_mem [c_DEPTH];
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [31:0]       r_addr;
  logic [31:0]       w_rd_addr;
  logic [ADDR_W-1:0] w_a;
  logic              w_accept;
  logic              w_err;
  logic [31:0]       w_rd_word;

  assign w_accept = fetch_req & fetch_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_IDLE, c_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = c_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = c_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      c_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = c_RESP;
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    fetch_ready = ((r_state == c_IDLE) || (r_state == c_RESP)) && !load_en;
    busy        = (r_state == c_WAIT);
    instr_valid = (r_state == c_RESP);
  end

  // With LATENCY=1 the RESP-entry edge is also the accept edge, so the
  // address is taken straight from the port rather than the capture register.
  assign w_rd_addr = w_accept ? fetch_addr : r_addr;
  assign w_a       = w_rd_addr[ADDR_W-1:0];
  assign w_err     = (|w_rd_addr[1:0]) | (|w_rd_addr[31:ADDR_W]);
  assign w_rd_word = {r_mem[w_a], r_mem[w_a + ADDR_W'(1)],
                      r_mem[w_a + ADDR_W'(2)], r_mem[w_a + ADDR_W'(3)]};

  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  // Reads see pre-edge memory, so a same-edge load is not visible here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= 32'h0;
      instr_out <= 32'h0;
      addr_err  <= 1'b0;
    end else begin
      if (w_accept) r_addr <= fetch_addr;
      if (w_state_nxt == c_RESP) begin
        instr_out <= w_err ? 32'h0 : w_rd_word;
        addr_err  <= w_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_instr_fetch_responder
// Brief    : Directed bench for instr_fetch_responder at LATENCY 2, 1 and 4.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_instr_fetch_responder;

  localparam int ADDR_W = 9;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [2:0]        fr;
  logic [31:0]       fa [3];
  logic [2:0]        rdy, val, err, bsy;
  logic [31:0]       ins [3];

  int checks = 0;
  int errors = 0;
  int lat [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  instr_fetch_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_req(fr[0]), .fetch_addr(fa[0]),
    .fetch_ready(rdy[0]), .instr_valid(val[0]), .instr_out(ins[0]),
    .addr_err(err[0]), .busy(bsy[0]));

  instr_fetch_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_req(fr[1]), .fetch_addr(fa[1]),
    .fetch_ready(rdy[1]), .instr_valid(val[1]), .instr_out(ins[1]),
    .addr_err(err[1]), .busy(bsy[1]));

  instr_fetch_responder #(.ADDR_W(ADDR_W), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_req(fr[2]), .fetch_addr(fa[2]),
    .fetch_ready(rdy[2]), .instr_valid(val[2]), .instr_out(ins[2]),
    .addr_err(err[2]), .busy(bsy[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called and returns at a falling edge.
  task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    load_byte(a,                w[31:24]);
    load_byte(a + ADDR_W'(1),   w[23:16]);
    load_byte(a + ADDR_W'(2),   w[15:8]);
    load_byte(a + ADDR_W'(3),   w[7:0]);
  endtask

  task automatic do_fetch(input int k, input logic [31:0] addr,
                          input logic [31:0] exp_i, input logic exp_e, input string nm);
    int n;
    fr[k] = 1'b1;
    fa[k] = addr;
    #1;
    chk({nm, " ready"}, 32'(rdy[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    fr[k] = 1'b0;
    n = 1;
    while (!val[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat[k]));
    chk({nm, " instr"}, ins[k], exp_i);
    chk({nm, " err"}, 32'(err[k]), 32'(exp_e));
    @(negedge clk);
    chk({nm, " pulse_end"}, 32'(val[k]), 32'd0);
  endtask

  vec_t tbl [8];
  int   n_valid;

  initial begin
    tbl[0] = '{32'h0000_0000, 32'h2402_0005, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h8C43_0010, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0043_2020, 1'b0};
    tbl[3] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    tbl[4] = '{32'h0000_0200, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_01FC, 32'h1000_FFFF, 1'b0};
    tbl[6] = '{32'h0000_01FD, 32'h0000_0000, 1'b1};
    tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; fr = '0;
    for (int i = 0; i < 3; i++) fa[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(val[0]), 32'd0);
    chk("rst instr", ins[0], 32'h0);
    chk("rst err",   32'(err[0]), 32'd0);
    chk("rst busy",  32'(bsy[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel ready", 32'(rdy[0]), 32'd1);

    load_word(9'd0,   32'h2402_0005);
    load_word(9'd4,   32'h8C43_0010);
    load_word(9'd8,   32'h0043_2020);
    load_word(9'd508, 32'h1000_FFFF);

    // First LATENCY=2 fetch: busy for exactly one cycle before the pulse.
    fr[0] = 1'b1; fa[0] = 32'h0;
    @(posedge clk); @(negedge clk);
    fr[0] = 1'b0;
    chk("l2 busy", 32'(bsy[0]), 32'd1);
    chk("l2 wait_valid", 32'(val[0]), 32'd0);
    @(negedge clk);
    chk("l2 busy_end", 32'(bsy[0]), 32'd0);
    chk("l2 valid", 32'(val[0]), 32'd1);
    chk("l2 instr", ins[0], 32'h2402_0005);
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_fetch(0, tbl[i].addr, tbl[i].instr, tbl[i].err, $sformatf("vec%0d", i));
    chk("hold instr", ins[0], 32'h0);
    chk("hold err",   32'(err[0]), 32'd1);

    // LATENCY=1 back-to-back: a pulse every cycle, ready never drops.
    fr[1] = 1'b1; fa[1] = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("b2b0 valid", 32'(val[1]), 32'd1);
    chk("b2b0 instr", ins[1], 32'h2402_0005);
    chk("b2b0 ready", 32'(rdy[1]), 32'd1);
    fa[1] = 32'h4;
    @(posedge clk); @(negedge clk);
    chk("b2b1 valid", 32'(val[1]), 32'd1);
    chk("b2b1 instr", ins[1], 32'h8C43_0010);
    chk("b2b1 ready", 32'(rdy[1]), 32'd1);
    fa[1] = 32'h8;
    @(posedge clk); @(negedge clk);
    fr[1] = 1'b0;
    chk("b2b2 valid", 32'(val[1]), 32'd1);
    chk("b2b2 instr", ins[1], 32'h0043_2020);
    @(negedge clk);
    chk("b2b end", 32'(val[1]), 32'd0);

    // Load and fetch on the same edge: load wins, fetch accepted next cycle.
    load_en = 1'b1; load_addr = 9'd100; load_data = 8'h55;
    fr[0] = 1'b1; fa[0] = 32'h4;
    #1;
    chk("coll ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); @(negedge clk);
    load_en = 1'b0;
    chk("coll no_accept", 32'(bsy[0]), 32'd0);
    @(posedge clk); @(negedge clk);
    fr[0] = 1'b0;
    chk("coll accept", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("coll valid", 32'(val[0]), 32'd1);
    chk("coll instr", ins[0], 32'h8C43_0010);
    @(negedge clk);

    // Load to a+2 on the RESP-entry edge is not seen until the refetch.
    fr[0] = 1'b1; fa[0] = 32'h4;
    @(posedge clk); @(negedge clk);
    fr[0] = 1'b0;
    fa[0] = 32'hFFFF_FFFF;
    load_en = 1'b1; load_addr = 9'd6; load_data = 8'hAA;
    @(posedge clk); @(negedge clk);
    load_en = 1'b0;
    chk("rbw valid", 32'(val[0]), 32'd1);
    chk("rbw old", ins[0], 32'h8C43_0010);
    @(negedge clk);
    do_fetch(0, 32'h4, 32'h8C43_AA10, 1'b0, "rbw new");

    // LATENCY=4: reset two cycles into a fetch aborts it.
    do_fetch(2, 32'h4, 32'h8C43_AA10, 1'b0, "l4 pre");
    fr[2] = 1'b1; fa[2] = 32'h8;
    @(posedge clk); @(negedge clk);
    fr[2] = 1'b0;
    chk("l4 busy", 32'(bsy[2]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst busy",  32'(bsy[2]), 32'd0);
    chk("mid rst valid", 32'(val[2]), 32'd0);
    chk("mid rst instr", ins[2], 32'h0);
    chk("mid rst err",   32'(err[2]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (val[2]) n_valid++;
    end
    chk("mid rst no_valid", 32'(n_valid), 32'd0);
    do_fetch(2, 32'h8, 32'h0043_2020, 1'b0, "l4 refetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
